layer_out_serializer: RTL and testbench
=======================================

# layer_out_serializer

Collects the parallel activation outputs of one fully-connected layer of neurons and streams them out one word per beat, as the `myinput`/`myinputValid` stream of the next layer. It sits directly downstream of the neuron array: it captures all `NUM_NEURONS` outputs on the layer's `outvalid` strobe and replays them in neuron order. It also applies ready/valid backpressure on the output side. It optionally tracks the arg-max for use as the final classifier stage.

## Interface
Parameters:
- `NUM_NEURONS`, 30 — neurons in the upstream layer; must be ≥ 2.
- `IN_W`, 16 — width of each neuron output (`ROM_bitwidth`).
- `DATA_W`, 16 — width of the downstream input word (`dataWidth`).
- `IDX_W`, `$clog2(NUM_NEURONS)` — index width.

Ports:
- `clk`, input, 1 — clock.
- `rst`, input, 1 — reset; synchronous, active-high.
- `in_data`, input, `NUM_NEURONS*IN_W` — flattened neuron outputs; neuron k occupies bits `[k*IN_W +: IN_W]`.
- `in_valid`, input, 1 — single-cycle strobe; all neuron outputs are valid in this cycle.
- `out_data`, output, `DATA_W` — current word.
- `out_valid`, output, 1 — `out_data` is valid.
- `out_ready`, input, 1 — downstream accepts the word.
- `out_last`, output, 1 — current word is neuron `NUM_NEURONS-1`.
- `out_idx`, output, `IDX_W` — neuron index of the current word.
- `busy`, output, 1 — a frame is held (state ≠ IDLE).
- `overrun`, output, 1 — sticky flag: an `in_valid` strobe was dropped.
- `max_idx`, output, `IDX_W` — arg-max index (`MAX_FINDER_EN` only).
- `max_val`, output, `DATA_W` — maximum value (`MAX_FINDER_EN` only).
- `max_valid`, output, 1 — one-cycle strobe (`MAX_FINDER_EN` only).

## Operation
- States: IDLE, SEND, plus REPORT when `MAX_FINDER_EN` is defined.
- IDLE:
  - On `in_valid`, register all words into a frame buffer, set `idx` = 0, and go to SEND.
- SEND:
  - `out_valid` = 1, `out_data` = buffer[`idx`], `out_idx` = `idx`, `out_last` = (`idx` == `NUM_NEURONS-1`).
  - A beat transfers when `out_valid & out_ready`; `idx` then increments.
  - On the transfer of the last beat, go to IDLE, or to REPORT when `MAX_FINDER_EN` is defined.
  - While `out_ready` is low, `out_data`, `out_idx` and `out_last` are held stable.
- REPORT: lasts one cycle; `max_valid` = 1; then go to IDLE.
- Width rule, applied at capture:
  - `IN_W` < `DATA_W`: zero-extend.
  - `IN_W` > `DATA_W`: keep the upper `DATA_W` bits.
  - Equal widths: pass through unchanged.
- Overrun:
  - `in_valid` in any state other than IDLE is dropped, including on the last-beat cycle.
  - A dropped strobe sets `overrun`, which stays set until `rst`.
  - The frame in flight is unaffected.
- Reset:
  - Every output is 0: `out_valid`, `out_last`, `out_idx`, `out_data`, `busy`, `overrun`, `max_*`.
  - State returns to IDLE.
  - A reset mid-frame abandons the frame; the next beat is produced only after a new `in_valid`.

## Timing
- `in_valid` sampled high at edge t (in IDLE): `out_valid` is high from the cycle after t, with word 0.
- With `out_ready` held high, words 0..`NUM_NEURONS-1` appear on consecutive cycles. A frame takes `NUM_NEURONS` cycles, with `busy` high throughout.
- `busy` is combinational on state.
- `out_data` is registered (taken from the buffer through a registered mux or an equivalent). There is no bubble between beats under continuous ready.
- IDLE is re-entered on the edge that transfers the last beat. A new `in_valid` is accepted from the following cycle onward.
- With `MAX_FINDER_EN` defined, `max_valid` pulses in the cycle after the last beat transfer, and IDLE follows one cycle later.

## Configuration
- `MAX_FINDER_EN` defined:
  - During SEND, each transferred word is compared (unsigned) against a running maximum.
  - The running maximum is initialised from word 0.
  - Strictly-greater comparison, so ties keep the lowest index.
  - `max_idx`/`max_val` are valid and held from the `max_valid` strobe until the next frame's REPORT.
  - The REPORT state exists.
- `MAX_FINDER_EN` not defined:
  - No comparator or REPORT state.
  - `max_idx`, `max_val` and `max_valid` are tied to 0.

## Test plan
- Reset, then `in_valid` with `NUM_NEURONS`=4, `IN_W`=`DATA_W`=16, words {0x0010, 0x0200, 0x0030, 0x0200}, `out_ready`=1 → beats 0x0010, 0x0200, 0x0030, 0x0200 on 4 consecutive cycles; `out_last` only on beat 3; `busy` low afterwards.
- Same frame with `out_ready` toggling 1,0,0,1,… → each word held stable while stalled; no word lost or duplicated; `out_idx` sequence 0..3.
- `in_valid` pulsed during beat 2 and again on the last-beat cycle → both dropped; `overrun` = 1 and stays 1; the in-flight frame is intact.
- `rst` asserted at beat 1 → all outputs 0 the next cycle; a fresh frame with {1,2,3,4} streams correctly from word 0.
- With `MAX_FINDER_EN` defined and the first frame → `max_valid` one cycle after the last beat, `max_idx`=1, `max_val`=0x0200 (tie resolved to the lower index).
- `IN_W`=8, `DATA_W`=16, word 0xA5 → `out_data`=0x00A5; `IN_W`=16, `DATA_W`=8, word 0xA5C3 → `out_data`=0xA5.

Source files
------------

// File: rtl/layer_out_serializer.sv
// Captures one layer's parallel neuron outputs and replays them as a ready/valid word stream.
// Optional arg-max tracking and REPORT state are enabled with `define MAX_FINDER_EN.
module layer_out_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int IN_W        = 16,
    parameter int DATA_W      = 16,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_NEURONS*IN_W-1:0] in_data,
    input  logic                        in_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        busy,
    output logic                        overrun,
    output logic [IDX_W-1:0]            max_idx,
    output logic [DATA_W-1:0]           max_val,
    output logic                        max_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND
`ifdef MAX_FINDER_EN
        , S_REPORT
`endif
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_inc;
    logic [DATA_W-1:0] data_q;
    logic              overrun_q;
    logic              capture;
    logic              xfer;
    logic              last_beat;
    logic [DATA_W-1:0] conv      [NUM_NEURONS];
    logic [DATA_W-1:0] frame_buf [NUM_NEURONS];

    // Width adaptation happens once at capture so the buffer already holds downstream words.
    for (genvar k = 0; k < NUM_NEURONS; k++) begin : g_conv
        if (IN_W < DATA_W) begin : g_zext
            assign conv[k] = {{(DATA_W - IN_W){1'b0}}, in_data[k*IN_W +: IN_W]};
        end else if (IN_W > DATA_W) begin : g_trunc
            assign conv[k] = in_data[k*IN_W + (IN_W - DATA_W) +: DATA_W];
        end else begin : g_pass
            assign conv[k] = in_data[k*IN_W +: IN_W];
        end
    end

    assign capture   = (state == S_IDLE) && in_valid;
    assign out_valid = (state == S_SEND);
    assign xfer      = out_valid && out_ready;
    assign last_beat = (idx == LAST_IDX);
    assign idx_inc   = idx + IDX_W'(1);
    assign out_last  = out_valid && last_beat;
    assign out_idx   = idx;
    assign out_data  = data_q;
    assign busy      = (state != S_IDLE);
    assign overrun   = overrun_q;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: next-state is assigned a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (in_valid) state_next = S_SEND;
            S_SEND: begin
                if (xfer && last_beat) begin
`ifdef MAX_FINDER_EN
                    state_next = S_REPORT;
`else
                    state_next = S_IDLE;
`endif
                end
            end
`ifdef MAX_FINDER_EN
            S_REPORT: state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Word 0 goes straight from the inputs so the first beat leaves the cycle after capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (in_valid && (state != S_IDLE)) overrun_q <= 1'b1;
            if (capture) begin
                idx    <= '0;
                data_q <= conv[0];
            end else if (xfer) begin
                if (last_beat) begin
                    idx <= '0;
                end else begin
                    idx    <= idx_inc;
                    data_q <= frame_buf[idx_inc];
                end
            end
        end
    end

    // NOTE: the frame buffer has no reset; it is always fully rewritten before it is read.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < NUM_NEURONS; k++) frame_buf[k] <= conv[k];
        end
    end

`ifdef MAX_FINDER_EN
    logic [DATA_W-1:0] run_val;
    logic [IDX_W-1:0]  run_idx;
    logic [DATA_W-1:0] max_val_q;
    logic [IDX_W-1:0]  max_idx_q;
    logic              take;

    // Strictly greater keeps the lowest index on ties; beat 0 seeds the running maximum.
    assign take = (idx == '0) || (data_q > run_val);

    always_ff @(posedge clk) begin
        if (rst) begin
            run_val   <= '0;
            run_idx   <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
        end else if (xfer) begin
            run_val <= take ? data_q : run_val;
            run_idx <= take ? idx    : run_idx;
            if (last_beat) begin
                max_val_q <= take ? data_q : run_val;
                max_idx_q <= take ? idx    : run_idx;
            end
        end
    end

    assign max_valid = (state == S_REPORT);
    assign max_val   = max_val_q;
    assign max_idx   = max_idx_q;
`else
    assign max_valid = 1'b0;
    assign max_val   = '0;
    assign max_idx   = '0;
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// Randomised self-checking bench for layer_out_serializer against a frame-level reference model.
// Main instance streams 4 x 16-bit frames; two 2-neuron instances check the width rules.
module tb_layer_out_serializer;

    localparam int N  = 4;
    localparam int IW = 16;
    localparam int DW = 16;
    localparam int XW = $clog2(N);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N*IW-1:0] in_data;
    logic            in_valid;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic [XW-1:0]   out_idx;
    logic            busy;
    logic            overrun;
    logic [XW-1:0]   max_idx;
    logic [DW-1:0]   max_val;
    logic            max_valid;

    layer_out_serializer #(.NUM_NEURONS(N), .IN_W(IW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .out_idx(out_idx), .busy(busy), .overrun(overrun),
        .max_idx(max_idx), .max_val(max_val), .max_valid(max_valid)
    );

    // Width-rule instances: narrow input (8 -> 16) and wide input (16 -> 8).
    logic        in_valid_x;
    logic        out_ready_x;
    logic [15:0] in_data_n;
    logic [15:0] out_data_n;
    logic        out_valid_n, out_last_n, busy_n, overrun_n, max_valid_n;
    logic [0:0]  out_idx_n, max_idx_n;
    logic [15:0] max_val_n;
    logic [31:0] in_data_w;
    logic [7:0]  out_data_w;
    logic        out_valid_w, out_last_w, busy_w, overrun_w, max_valid_w;
    logic [0:0]  out_idx_w, max_idx_w;
    logic [7:0]  max_val_w;

    layer_out_serializer #(.NUM_NEURONS(2), .IN_W(8), .DATA_W(16)) dut_n (
        .clk(clk), .rst(rst), .in_data(in_data_n), .in_valid(in_valid_x),
        .out_data(out_data_n), .out_valid(out_valid_n), .out_ready(out_ready_x),
        .out_last(out_last_n), .out_idx(out_idx_n), .busy(busy_n), .overrun(overrun_n),
        .max_idx(max_idx_n), .max_val(max_val_n), .max_valid(max_valid_n)
    );

    layer_out_serializer #(.NUM_NEURONS(2), .IN_W(16), .DATA_W(8)) dut_w (
        .clk(clk), .rst(rst), .in_data(in_data_w), .in_valid(in_valid_x),
        .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready_x),
        .out_last(out_last_w), .out_idx(out_idx_w), .busy(busy_w), .overrun(overrun_w),
        .max_idx(max_idx_w), .max_val(max_val_w), .max_valid(max_valid_w)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    logic [DW-1:0] words [N];
    bit          exp_overrun;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Arg-max of the current frame: first index holding the largest unsigned word.
    function automatic int ref_max_idx();
        int best = 0;
        for (int k = 1; k < N; k++) if (words[k] > words[best]) best = k;
        return best;
    endfunction

    // ready_mode: 0 = always ready, 1 = pattern 1,0,0,1 repeating, 2 = random.
    // inject pulses in_valid during beat 2 and on the last-beat cycle.
    task automatic run_frame(input int ready_mode, input bit inject);
        int  beat = 0;
        int  cyc  = 0;
        bit  rdy;
        bit  hit2 = 1'b0;
        int  bi;
        for (int k = 0; k < N; k++) in_data[k*IW +: IW] = words[k];
        check("idle_before_frame", busy, 0);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '1;
        while (beat < N && cyc < 200) begin
            check("out_valid", out_valid, 1);
            check("out_data", out_data, words[beat]);
            check("out_idx", out_idx, beat);
            check("out_last", out_last, beat == N - 1);
            check("busy", busy, 1);
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (inject && beat == N - 1) rdy = 1'b1;
            out_ready = rdy;
            in_valid  = 1'b0;
            if (inject && beat == 2 && !hit2) begin
                in_valid = 1'b1;
                hit2     = 1'b1;
            end
            if (inject && beat == N - 1) in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            if (rdy) beat++;
            cyc++;
        end
        if (beat < N) check("frame_timeout", beat, N);
        if (ready_mode == 0) check("frame_cycles", cyc, N);
        if (inject) exp_overrun = 1'b1;
        out_ready = 1'b0;
        bi = ref_max_idx();
        check("out_valid_after", out_valid, 0);
`ifdef MAX_FINDER_EN
        check("max_valid_pulse", max_valid, 1);
        check("max_idx", max_idx, bi);
        check("max_val", max_val, words[bi]);
        check("busy_report", busy, 1);
        @(negedge clk);
        check("max_valid_end", max_valid, 0);
        check("max_idx_held", max_idx, bi);
        check("busy_after", busy, 0);
`else
        check("busy_after", busy, 0);
        check("max_valid_off", max_valid, 0);
        check("max_idx_off", max_idx, 0);
        check("max_val_off", max_val, 0);
`endif
        check("overrun", overrun, exp_overrun);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_out_idx"}, out_idx, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_max_idx"}, max_idx, 0);
        check({tag, "_max_val"}, max_val, 0);
        check({tag, "_max_valid"}, max_valid, 0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        in_valid_x  = 1'b0;
        out_ready_x = 1'b1;
        in_data_n   = '0;
        in_data_w   = '0;
        exp_overrun = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        words = '{16'h0010, 16'h0200, 16'h0030, 16'h0200};
        run_frame(0, 1'b0);
        run_frame(1, 1'b0);
        run_frame(2, 1'b1);
        @(negedge clk);
        words = '{16'h0001, 16'hFFFF, 16'h0000, 16'h8000};
        run_frame(0, 1'b0);

        // Reset while beat 1 is on the bus abandons the frame.
        for (int k = 0; k < N; k++) in_data[k*IW +: IW] = words[k];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_idx", out_idx, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        rst         = 1'b0;
        out_ready   = 1'b0;
        exp_overrun = 1'b0;
        repeat (2) @(negedge clk);
        check("no_beat_after_reset", out_valid, 0);
        words = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_frame(0, 1'b0);

        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < N; k++)
                words[k] = (f % 2 == 0) ? DW'($urandom) : DW'($urandom_range(0, 3));
            run_frame(2, 1'b0);
        end

        in_data_n  = {8'h5A, 8'hA5};
        in_data_w  = {16'h1234, 16'hA5C3};
        in_valid_x = 1'b1;
        @(negedge clk);
        in_valid_x = 1'b0;
        check("zext_w0", out_data_n, 16'h00A5);
        check("trunc_w0", out_data_w, 8'hA5);
        check("zext_valid", out_valid_n, 1);
        @(negedge clk);
        check("zext_w1", out_data_n, 16'h005A);
        check("trunc_w1", out_data_w, 8'h12);
        check("zext_last", out_last_n, 1);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
